// File: rtl/im_loader.sv
// Instruction-memory loader: packs a host byte stream little-endian into 32-bit words and writes them out.
// Optional running XOR checksum of written words is enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count
`ifdef IM_LOADER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [31:0] wbuf;
    logic [31:0] word_next;
    logic        last_word;

    // Current buffer with the incoming byte dropped into its lane; upper lanes stay zero.
    always_comb begin
        word_next = wbuf | (32'(in_data) << {lane, 3'b000});
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            lane       <= '0;
            wbuf       <= '0;
            last_word  <= 1'b0;
            in_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
`ifdef IM_LOADER_CKSUM_EN
            cksum      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= COLLECT;
                        lane       <= '0;
                        wbuf       <= '0;
                        last_word  <= 1'b0;
                        in_ready   <= 1'b1;
                        im_addr    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        word_count <= '0;
`ifdef IM_LOADER_CKSUM_EN
                        cksum      <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        if (lane == 2'd3 || in_last) begin
                            state     <= WRITE;
                            in_ready  <= 1'b0;
                            im_we     <= 1'b1;
                            im_wdata  <= word_next;
                            last_word <= in_last;
                            wbuf      <= '0;
                            lane      <= '0;
                        end else begin
                            wbuf <= word_next;
                            lane <= lane + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    im_we      <= 1'b0;
                    word_count <= word_count + CNT_W'(1);
`ifdef IM_LOADER_CKSUM_EN
                    cksum      <= cksum ^ im_wdata;
`endif
                    // The address holds at the top word so a full session never wraps onto word 0.
                    if (word_count != LAST_COUNT) begin
                        im_addr <= im_addr + ADDR_W'(1);
                    end
                    if (last_word || word_count == LAST_COUNT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a byte-stream model predicts every memory write and session result.
module tb_im_loader;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   word_count;
`ifdef IM_LOADER_CKSUM_EN
    logic [31:0]       cksum;
`endif

    im_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
`ifdef IM_LOADER_CKSUM_EN
        ,
        .cksum      (cksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session model: bytes go in, whole words (address, data, due cycle) come out.
    int          m_count;
    int          m_lane;
    logic [31:0] m_word;
    logic [31:0] m_xor;
    int          q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    logic [31:0] sess_words[$];
    int          wr_total;
    int          wr_addr0;
    bit          cmp_en = 1'b0;

    function automatic void model_start();
        m_count = 0;
        m_lane  = 0;
        m_word  = '0;
        m_xor   = '0;
        sess_words.delete();
        wr_total = 0;
        wr_addr0 = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b, input logic last, input int c);
        m_word = m_word | (32'(b) << (8 * m_lane));
        m_lane++;
        if (m_lane == 4 || last) begin
            q_addr.push_back(m_count);
            q_data.push_back(m_word);
            q_cyc.push_back(c + 1);
            sess_words.push_back(m_word);
            m_xor = m_xor ^ m_word;
            m_count++;
            m_lane = 0;
            m_word = '0;
        end
    endfunction

    // Per-cycle comparison of the write port against the model, plus status invariants.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("inv_ready_needs_busy", 64'(in_ready & ~busy), 64'(0));
            chk("inv_done_not_busy", 64'(done & busy), 64'(0));
            if (im_we) begin
                chk("write_expected", 64'(q_addr.size() > 0), 64'(1));
                chk("ready_low_in_write", 64'(in_ready), 64'(0));
                if (q_addr.size() > 0) begin
                    chk("write_addr", 64'(im_addr), 64'(q_addr.pop_front()));
                    chk("write_data", 64'(im_wdata), 64'(q_data.pop_front()));
                    chk("write_latency", 64'(cyc), 64'(q_cyc.pop_front()));
                end
                wr_total++;
                if (im_addr == '0) wr_addr0++;
            end else if (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
                chk("write_missing", 64'(cyc), 64'(q_cyc[0]));
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                void'(q_cyc.pop_front());
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_start();
        chk("start_ready", 64'(in_ready), 64'(1));
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_done", 64'(done), 64'(0));
        chk("start_count", 64'(word_count), 64'(0));
`ifdef IM_LOADER_CKSUM_EN
        chk("start_cksum", 64'(cksum), 64'(0));
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        bit acc = 1'b0;
        int waited = 0;
        int c = 0;
        in_data  = b;
        in_last  = last;
        in_valid = 1'b1;
        while (!acc && waited <= 20) begin
            acc = in_ready;
            c = cyc;
            @(negedge clk);
            if (!acc) waited++;
        end
        if (acc) model_accept(b, last, c);
        else chk("byte_accept_timeout", 64'(acc), 64'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", 64'(done), 64'(1));
    endtask

    task automatic end_checks(input string tag);
        int exp_addr;
        exp_addr = (m_count > int'(DEPTH - 1)) ? int'(DEPTH - 1) : m_count;
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_count"}, 64'(word_count), 64'(m_count));
        chk({tag, "_addr"}, 64'(im_addr), 64'(exp_addr));
        chk({tag, "_writes"}, 64'(wr_total), 64'(m_count));
        chk({tag, "_pending"}, 64'(q_addr.size()), 64'(0));
`ifdef IM_LOADER_CKSUM_EN
        chk({tag, "_cksum"}, 64'(cksum), 64'(m_xor));
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t1 [4];
        t1[0] = 8'h3C; t1[1] = 8'h08; t1[2] = 8'h10; t1[3] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_we", 64'(im_we), 64'(0));
        chk("rst_addr", 64'(im_addr), 64'(0));
        chk("rst_wdata", 64'(im_wdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_count", 64'(word_count), 64'(0));
        model_start();
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(in_ready), 64'(0));

        // One full word, last on the 4th byte
        do_start();
        for (int i = 0; i < 4; i++) send_byte(t1[i], i == 3, 0);
        wait_done(10);
        end_checks("t1");
        chk("t1_pin_word", 64'(sess_words[0]), 64'h0010_083C);
        chk("t1_pin_count", 64'(word_count), 64'(1));

        // Bytes offered in DONE are ignored
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        end_checks("t1_idle_bytes");

        // Eight bytes, valid every other cycle
        do_start();
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), i == 7, 1);
        wait_done(10);
        end_checks("t2");
        chk("t2_pin_w0", 64'(sess_words[0]), 64'hA3A2_A1A0);
        chk("t2_pin_w1", 64'(sess_words[1]), 64'hA7A6_A5A4);

        // Partial final word, with a start pulse mid-session that must be ignored
        do_start();
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            send_byte(8'(8'h11 + i), i == 4, 0);
            start = 1'b0;
        end
        wait_done(10);
        end_checks("t3");
        chk("t3_pin_w1", 64'(sess_words[1]), 64'h0000_0015);
        chk("t3_pin_count", 64'(word_count), 64'(2));

        // Fill the whole memory without in_last
        do_start();
        for (int i = 0; i < 4 * int'(DEPTH); i++) send_byte(8'((i * 7 + 3) ^ (i >> 8)), 1'b0, 0);
        wait_done(10);
        end_checks("t4");
        chk("t4_pin_count", 64'(word_count), 64'(1024));
        chk("t4_pin_addr", 64'(im_addr), 64'(1023));
        chk("t4_addr0_once", 64'(wr_addr0), 64'(1));
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("t4_ready_after", 64'(in_ready), 64'(0));
        chk("t4_count_after", 64'(word_count), 64'(1024));

        // Reset at the edge that would start the second word's write
        do_start();
        for (int i = 0; i < 7; i++) send_byte(8'(8'h50 + i), 1'b0, 0);
        in_data  = 8'h57;
        in_valid = 1'b1;
        reset_n  = 1'b0;
        @(negedge clk);
        chk("t5_we", 64'(im_we), 64'(0));
        chk("t5_ready", 64'(in_ready), 64'(0));
        chk("t5_addr", 64'(im_addr), 64'(0));
        chk("t5_wdata", 64'(im_wdata), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_done", 64'(done), 64'(0));
        chk("t5_count", 64'(word_count), 64'(0));
        chk("t5_writes", 64'(wr_total), 64'(1));
`ifdef IM_LOADER_CKSUM_EN
        chk("t5_cksum", 64'(cksum), 64'(0));
`endif
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);

        // Fresh session after reset: single byte, lane buffer must start empty
        do_start();
        send_byte(8'hAB, 1'b1, 0);
        wait_done(10);
        end_checks("t6");
        chk("t6_pin_word", 64'(sess_words[0]), 64'h0000_00AB);

`ifdef IM_LOADER_CKSUM_EN
        do_start();
        send_byte(8'h78, 1'b0, 0);
        send_byte(8'h56, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h12, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_byte(8'h0F, i == 3, 0);
        wait_done(10);
        end_checks("t7");
        chk("t7_pin_cksum", 64'(cksum), 64'h1D3B_5977);
        do_start();
        chk("t7_cksum_cleared", 64'(cksum), 64'(0));
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (depth 2^ADDR_W = 1024 words).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a load session.
REQ-005 SHALL have port in_data  input  8  program byte from the host.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_last  input  1  final byte of program, qualified by in_valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port im_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port im_addr  output  ADDR_W  word address, equivalent to byte address bits [ADDR_W+1:2].
REQ-011 SHALL have port im_wdata  output  32  word to write.
REQ-012 SHALL have port busy  output  1  session in progress.
REQ-013 SHALL have port done  output  1  session complete; held until next start.
REQ-014 SHALL have port word_count  output  ADDR_W+1  words written this session.

Function
REQ-015 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-016 IDLE/DONE: start=1 -> COLLECT next cycle; byte lane, word_count and address cleared to 0, done cleared.
REQ-017 start SHALL be ignored in COLLECT and WRITE.
REQ-018 in_ready SHALL be 1 only in COLLECT; a byte is accepted when in_valid && in_ready.
REQ-019 Byte lanes little-endian: k-th accepted byte of a word (k=0..3) stored at bits [8k+7:8k].
REQ-020 On acceptance of lane 3, or of any byte with in_last=1, SHALL enter WRITE next cycle.
REQ-021 in_last on a partial word: unfilled upper lanes SHALL be written as 0x00.
REQ-022 WRITE lasts exactly one cycle: im_we=1, im_addr = current word address, im_wdata = assembled word; in_ready=0.
REQ-023 im_we SHALL be 0 in every state other than WRITE.
REQ-024 After WRITE: word_count and address increment by 1; lane buffer cleared to zero.
REQ-025 After WRITE: next state DONE if the word held in_last or word_count reaches 2^ADDR_W; else COLLECT.
REQ-026 Address SHALL never wrap: the session ends at 2^ADDR_W words, so address 0 is never overwritten in one session.
REQ-027 in_valid with in_ready=0 SHALL be ignored (byte not consumed, no state change).
REQ-028 busy SHALL be 1 in COLLECT and WRITE; done SHALL be 1 only in DONE.
REQ-029 Byte-to-write latency: 1 cycle from the accepting edge of the completing byte to im_we=1.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, word_count=0, lane buffer cleared.
REQ-031 Reset SHALL take priority over start and in_valid in the same cycle.
REQ-032 Reset asserted while in WRITE SHALL suppress the write (im_we=0 in the following cycle); no partial word retained.

Configuration
REQ-033 Macro IM_LOADER_CKSUM_EN defined: output port cksum [31:0] SHALL equal the XOR of all im_wdata values written this session; cleared by reset and by start; updated in the cycle after each WRITE.
REQ-034 Macro IM_LOADER_CKSUM_EN undefined: cksum port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset, then start; bytes 0x3C,0x08,0x10,0x00 (last on 4th) -> one im_we pulse, addr 0, wdata 0x0010083C; then done=1, word_count=1.
REQ-036 8 bytes, in_valid toggled every other cycle, last on 8th -> writes at addr 0 and 1, correct data, in_ready low during each WRITE cycle.
REQ-037 5 bytes 0x11..0x15, last on 5th -> word 1 written as 0x00000015, word_count=2.
REQ-038 Stream 4096 bytes, no last -> 1024 writes, final addr 1023, DONE after the 1024th write, in_ready=0 thereafter, addr 0 written exactly once.
REQ-039 reset_n=0 in the cycle the 2nd word's WRITE state is entered -> no im_we for that word, all outputs at reset values the following cycle.
REQ-040 With IM_LOADER_CKSUM_EN: words 0x12345678,0x0F0F0F0F -> cksum=0x1D3B5977; start again -> cksum=0.
